// File: rtl/tpu_stream_pkg.sv
// tpu_stream_pkg: shared stream-stage types, FIFO depth and handshake helper
package tpu_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int FIFO_DEPTH = 2;
  typedef logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt_t;
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;
  function automatic logic fire(input hs_t h);
    return h.valid & h.ready;
  endfunction
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: two-entry synchronous FIFO reused by the stream stages
module stream_fifo2 import tpu_stream_pkg::*; #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output fifo_cnt_t         count,
  output logic              full,
  output logic              empty
);
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = count == fifo_cnt_t'(FIFO_DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (!resetn) begin
      mem <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + fifo_cnt_t'(do_push) - fifo_cnt_t'(do_pop);
    end
endmodule

// File: rtl/dpram_read_streamer.sv
// dpram_read_streamer: streams num_words RAM words from base_addr over valid/ready
// Define DPRAM_STREAM_STRIDE_EN to add a per-transfer address stride input.
module dpram_read_streamer import tpu_stream_pkg::*; #(
  parameter int AWIDTH    = 10,
  parameter int DWIDTH    = 32,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [AWIDTH-1:0]    base_addr,
  input  logic [LEN_WIDTH-1:0] num_words,
`ifdef DPRAM_STREAM_STRIDE_EN
  input  logic [AWIDTH-1:0]    stride,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [AWIDTH-1:0]    ram_addr,
  output logic                 ram_wren,
  input  logic [DWIDTH-1:0]    ram_rdata,
  output logic [DWIDTH-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  state_t state, state_n;
  logic [AWIDTH-1:0] addr, last_addr, step;
  logic [LEN_WIDTH-1:0] len, issued, accepted;
  logic inflight, issue, pop, fifo_full, fifo_empty;
  fifo_cnt_t fifo_count;
  logic [2:0] occ;
  hs_t out_hs;
  assign out_hs = '{valid: out_valid, ready: out_ready};
  assign pop = fire(out_hs);
  // occupancy counts the read already on its way back from the RAM
  assign occ = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign issue = state == RUN && !(fifo_full && !pop) && occ < 3'(FIFO_DEPTH);
  assign out_valid = ~fifo_empty;
  assign ram_wren = 1'b0;
`ifdef DPRAM_STREAM_STRIDE_EN
  always_ff @(posedge clk)
    if (!resetn) step <= AWIDTH'(1);
    else if (state == IDLE && start) step <= stride;
`else
  assign step = AWIDTH'(1);
`endif
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : num_words == '0 ? DONE : RUN;
      RUN:     state_n = issue && issued + LEN_WIDTH'(1) == len ? DRAIN : RUN;
      DRAIN:   state_n = pop && accepted + LEN_WIDTH'(1) == len ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    ram_addr = issue ? addr : last_addr;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      addr <= '0;
      last_addr <= '0;
      len <= '0;
      issued <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE && start) begin
        addr <= base_addr;
        len <= num_words;
        issued <= '0;
        accepted <= '0;
      end
      if (issue) begin
        last_addr <= addr;
        addr <= addr + step;
        issued <= issued + LEN_WIDTH'(1);
      end
      if (pop) accepted <= accepted + LEN_WIDTH'(1);
    end
  stream_fifo2 #(.DWIDTH(DWIDTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(inflight),
    .pop(pop),
    .din(ram_rdata),
    .dout(out_data),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_dpram_read_streamer.sv
// tb_dpram_read_streamer: directed bench with a queue model of the expected word stream
module tb_dpram_read_streamer;
  logic clk = 1'b0, resetn, start, ram_wren, busy, done, out_valid, out_ready;
  logic [9:0] base_addr, ram_addr, stride;
  logic [10:0] num_words;
  logic [31:0] ram_rdata, out_data, prev_data;
  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];
  int total = 0, bad = 0, cyc = 0, acc = 0, t0 = 0, dc;
  bit prev_stall = 1'b0;
  logic bz [1:8], dn [1:8], vl [1:8];
  logic [31:0] dt [1:8];
  logic [9:0] ad [1:8];

  dpram_read_streamer dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .base_addr(base_addr),
    .num_words(num_words),
`ifdef DPRAM_STREAM_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_wren(ram_wren),
    .ram_rdata(ram_rdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      check("wren_low", ram_wren, 0);
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        acc++;
        if (exp_q.size() == 0) check("extra_word", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("word", out_data, exp_q.pop_front());
      end
      if (done) check("done_q_empty", exp_q.size(), 0);
    end
    prev_stall = resetn && out_valid && !out_ready;
    prev_data = out_data;
  end

  task automatic start_xfer(input int b, input int n, input int s);
    start = 1'b1;
    base_addr = 10'(b);
    num_words = 11'(n);
    stride = 10'(s);
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i * s) % 1024]);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit tog, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (tog) out_ready = (i % 3 == 0);
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_seen", dcyc >= 0, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_wren"}, ram_wren, 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; stride = 10'd1; out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 100);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    // basic stream with timing pinned against hand-computed cycles
    start_xfer(5, 4, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bz[k] = busy; dn[k] = done; vl[k] = out_valid; dt[k] = out_data; ad[k] = ram_addr;
    end
    @(posedge clk); #1;
    check("t1_first_addr", ad[1], 5);
    check("t1_valid_t2", vl[2], 0);
    for (int k = 3; k <= 6; k++) begin
      check("t1_valid", vl[k], 1);
      check("t1_data", dt[k], 32'(102 + k));
    end
    check("t1_done_t6", dn[6], 0);
    check("t1_done_t7", dn[7], 1);
    check("t1_busy_t1", bz[1], 1);
    check("t1_busy_t7", bz[7], 1);
    check("t1_busy_t8", bz[8], 0);
    // backpressure with ready pattern 1,0,0
    start_xfer(5, 4, 1);
    wait_done(200, 1'b1, dc);
    check("t2_all_words", exp_q.size(), 0);
    // address wrap
    start_xfer(1022, 4, 1);
    check("t3_model_first", exp_q[0], 1122);
    check("t3_model_wrap", exp_q[2], 100);
    wait_done(100, 1'b0, dc);
    check("t3_done_cycle", dc, t0 + 7);
    // zero-length transfer
    start_xfer(300, 0, 1);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_busy", busy, 1);
    check("t4_valid", out_valid, 0);
    check("t4_addr_hold", ram_addr, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_busy_after", busy, 0);
    check("t4_done_after", done, 0);
    @(posedge clk); #1;
    // reset mid-transfer after 3 accepted words
    acc = 0;
    start_xfer(0, 16, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (acc >= 3) break;
      @(posedge clk); #1;
    end
    check("t5_three_accepted", acc >= 3, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1;
    start_xfer(0, 2, 1);
    start = 1'b1; base_addr = 10'd500; num_words = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, 1'b0, dc);
    check("t5_done_cycle", dc, t0 + 5);
    repeat (3) @(posedge clk);
    #1;
    check("t5_idle_busy", busy, 0);
    check("t5_idle_valid", out_valid, 0);
`ifdef DPRAM_STREAM_STRIDE_EN
    start_xfer(0, 3, 16);
    check("t6_model_stride", exp_q[2], 132);
    wait_done(100, 1'b0, dc);
    start_xfer(0, 2, 0);
    check("t6_model_zero", exp_q[1], 100);
    wait_done(100, 1'b0, dc);
`endif
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpram_read_streamer.md
Name: dpram_read_streamer

Overview:
- Downstream consumer of one read port of the team's dual-port RAM (1-cycle registered read, no read enable).
- On `start`, reads `num_words` consecutive words beginning at `base_addr` and streams them out over a valid/ready interface toward the systolic-array input.
- Hides the RAM read latency and absorbs backpressure with a 2-entry output FIFO, sustaining 1 word/cycle when the sink is always ready.

Parameters:
- AWIDTH, 10, RAM address width; addresses wrap modulo 2^AWIDTH.
- DWIDTH, 32, word width; must match the RAM.
- LEN_WIDTH, 11, width of `num_words`; allows 0..2^AWIDTH words.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- base_addr  input  AWIDTH  first address; captured with `start`.
- num_words  input  LEN_WIDTH  word count; captured with `start`.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- ram_addr  output  AWIDTH  connects to the RAM port address.
- ram_wren  output  1  connects to the RAM port write enable; constant 0.
- ram_rdata  input  DWIDTH  RAM port read data (1-cycle latency).
- out_data  output  DWIDTH  streamed word.
- out_valid  output  1  `out_data` is valid.
- out_ready  input  1  sink accepts the word.

Behaviour:
- Reset values (resetn low at an edge): busy=0, done=0, out_valid=0, out_data=0, ram_addr=0, ram_wren=0. FIFO is emptied, the in-flight flag is cleared, state goes to IDLE. Reset mid-transfer aborts the transfer, discards the in-flight read, and produces no done pulse.
- States:
  - IDLE → RUN on start=1 with num_words≠0; base_addr and num_words are latched.
  - IDLE → DONE on start=1 with num_words=0.
  - RUN → DRAIN when the last address has been issued.
  - DRAIN → DONE when the last word has been handshaken.
  - DONE → IDLE after 1 cycle.
- `start` is ignored outside IDLE.
- `busy` is 1 in RUN, DRAIN and DONE.
- `done` is 1 only in DONE.
- Issue rule (RUN only): a read is issued in a cycle when `fifo_count + inflight − pop < 2`, where `pop = out_valid & out_ready`.
  - On issue: `ram_addr` is the current address, `inflight` is set for the next cycle, and the address is incremented by 1 (or by the stride, see Optional Feature) modulo 2^AWIDTH.
  - `ram_addr` holds its last value when no read is issued; the RAM output is ignored unless `inflight` is set.
- Read data: when `inflight` is set, `ram_rdata` is pushed into the FIFO at the end of that cycle. Push and pop in the same cycle are legal; count is unchanged.
- Latency: with `start` accepted in cycle T and out_ready=1, the first address appears in T+1 and out_valid rises in T+3. Words then stream back-to-back with no bubbles.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid are held stable. The FIFO never overflows; the issue rule guarantees this.
- done timing: the pulse occurs in the cycle after the handshake of the final word.
- Counters: the issued and accepted counters are LEN_WIDTH bits. num_words=2^AWIDTH reads every RAM word once, including the wrap back to base_addr.

Optional Feature:
- Macro: DPRAM_STREAM_STRIDE_EN.
- Defined: adds input port `stride` [AWIDTH-1:0], captured with `start`. The address advances by `stride` per issue, modulo 2^AWIDTH. stride=0 re-reads base_addr num_words times.
- Undefined: no `stride` port; the increment is a constant 1.

Decomposition:
- Package `tpu_stream_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - FIFO depth constant (2)
  - shared valid/ready helper typedefs
- Sub-module `stream_fifo2`: a 2-entry synchronous FIFO (push, pop, data, count, full, empty) with reset under resetn. It is reused by other stream stages.

Test Plan:
- Preload RAM[i]=i+100. Start with base=5, num=4, out_ready=1 → out_data 105,106,107,108 on cycles T+3..T+6. done pulses at T+7; busy is 1 for T+1..T+7.
- Same load with out_ready toggling 1,0,0,1,… → all 4 words delivered in order, no duplicates, out_data stable while stalled, and no more than 2 words buffered.
- base=1022, num=4 → words from addresses 1022, 1023, 0, 1.
- num=0 → done at T+1, busy at T+1 only, out_valid never rises, no address issued.
- resetn low for 1 cycle during a 16-word transfer after 3 words accepted → all outputs return to reset values. A subsequent start with base=0, num=2 completes normally; start pulses during busy are ignored.
- With DPRAM_STREAM_STRIDE_EN: base=0, stride=16, num=3 → words from addresses 0, 16, 32. With stride=0, num=2 → RAM[0] twice.
